// File: rtl/axil_arb_2to1.sv
// axil_arb_2to1
// Two-requester AXI4-Lite arbiter that shares one AXI4-Lite slave between
// requesters s0 and s1, for example instruction fetch and data/debug paths.
// The read and write channels arbitrate independently. Each channel allows
// one outstanding transaction.
//
// Optional build macro: AXIL_ARB_FIXED_PRIO_EN
//   defined   : s0 always wins simultaneous requests (s1 can starve);
//               RR_INIT and the priority registers are not used.
//   undefined : round-robin. Priority flips to the other port after each
//               completed transaction, held separately per channel.
//
// Parameters
//   RR_INIT  port holding round-robin priority after reset (0 = s0, 1 = s1)
//   ADDR_W   address width
//   DATA_W   data width (strobe width is DATA_W/8)
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   s0_*, s1_*         requester-facing AXI4-Lite slave ports (aw/w/b/ar/r)
//   m_*                downstream AXI4-Lite master port to the shared RAM
//   wr_gnt, rd_gnt     one-hot grants (bit i = si owns the channel), 0 when idle
//   wr_state_dbg       write FSM state (0 idle, 1 addr/data, 2 response)
//   rd_state_dbg       read FSM state  (0 idle, 1 address, 2 data)
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. Valids come from the source, readies from the sink.
// This block never drops a valid it has not accepted. An ungranted
// requester sees all of its readies held at 0, so its request stays pending.
// Readies toward the granted requester are combinational copies of the m_*
// readies, gated by the channel phase.
module axil_arb_2to1 #(
  parameter logic RR_INIT = 1'b0,
  parameter int   ADDR_W  = 32,
  parameter int   DATA_W  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  // requester 0
  input  logic                s0_aw_valid,
  output logic                s0_aw_ready,
  input  logic [ADDR_W-1:0]   s0_aw_addr,
  input  logic [2:0]          s0_aw_prot,
  input  logic                s0_w_valid,
  output logic                s0_w_ready,
  input  logic [DATA_W-1:0]   s0_w_data,
  input  logic [DATA_W/8-1:0] s0_w_strb,
  output logic                s0_b_valid,
  input  logic                s0_b_ready,
  output logic [1:0]          s0_b_resp,
  input  logic                s0_ar_valid,
  output logic                s0_ar_ready,
  input  logic [ADDR_W-1:0]   s0_ar_addr,
  input  logic [2:0]          s0_ar_prot,
  output logic                s0_r_valid,
  input  logic                s0_r_ready,
  output logic [DATA_W-1:0]   s0_r_data,
  output logic [1:0]          s0_r_resp,
  // requester 1
  input  logic                s1_aw_valid,
  output logic                s1_aw_ready,
  input  logic [ADDR_W-1:0]   s1_aw_addr,
  input  logic [2:0]          s1_aw_prot,
  input  logic                s1_w_valid,
  output logic                s1_w_ready,
  input  logic [DATA_W-1:0]   s1_w_data,
  input  logic [DATA_W/8-1:0] s1_w_strb,
  output logic                s1_b_valid,
  input  logic                s1_b_ready,
  output logic [1:0]          s1_b_resp,
  input  logic                s1_ar_valid,
  output logic                s1_ar_ready,
  input  logic [ADDR_W-1:0]   s1_ar_addr,
  input  logic [2:0]          s1_ar_prot,
  output logic                s1_r_valid,
  input  logic                s1_r_ready,
  output logic [DATA_W-1:0]   s1_r_data,
  output logic [1:0]          s1_r_resp,
  // shared downstream port
  output logic                m_aw_valid,
  input  logic                m_aw_ready,
  output logic [ADDR_W-1:0]   m_aw_addr,
  output logic [2:0]          m_aw_prot,
  output logic                m_w_valid,
  input  logic                m_w_ready,
  output logic [DATA_W-1:0]   m_w_data,
  output logic [DATA_W/8-1:0] m_w_strb,
  input  logic                m_b_valid,
  output logic                m_b_ready,
  input  logic [1:0]          m_b_resp,
  output logic                m_ar_valid,
  input  logic                m_ar_ready,
  output logic [ADDR_W-1:0]   m_ar_addr,
  output logic [2:0]          m_ar_prot,
  input  logic                m_r_valid,
  output logic                m_r_ready,
  input  logic [DATA_W-1:0]   m_r_data,
  input  logic [1:0]          m_r_resp,
  // grants and debug
  output logic [1:0]          wr_gnt,
  output logic [1:0]          rd_gnt,
  output logic [1:0]          wr_state_dbg,
  output logic [1:0]          rd_state_dbg
);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} r_state_t;

  w_state_t w_state, w_state_d;
  r_state_t r_state, r_state_d;

  logic w_sel, w_sel_d;        // granted write port (0 = s0, 1 = s1)
  logic r_sel, r_sel_d;        // granted read port
  logic aw_done, aw_done_d;    // AW already accepted downstream
  logic w_done, w_done_d;      // W already accepted downstream
  logic w_flip, r_flip;        // transaction completed this cycle
  logic w_pick, r_pick;        // arbitration winner while idle

  // ---------------------------------------------------------------------
  // Priority selection
  // ---------------------------------------------------------------------
`ifdef AXIL_ARB_FIXED_PRIO_EN
  // s0 takes the channel whenever it asks; s1 only when s0 is silent.
  assign w_pick = ~s0_aw_valid;
  assign r_pick = ~s0_ar_valid;

  logic unused_rr;
  assign unused_rr = ^{RR_INIT, w_flip, r_flip};
`else
  logic w_prio, r_prio;        // port that wins the next simultaneous request

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_prio <= RR_INIT;
      r_prio <= RR_INIT;
    end else begin
      // Priority only moves on a completed transaction. The loser of a
      // contest therefore wins the next one, even if the winner re-requests
      // immediately.
      if (w_flip) w_prio <= ~w_sel;
      if (r_flip) r_prio <= ~r_sel;
    end
  end

  assign w_pick = (s0_aw_valid & s1_aw_valid) ? w_prio : s1_aw_valid;
  assign r_pick = (s0_ar_valid & s1_ar_valid) ? r_prio : s1_ar_valid;
`endif

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      w_sel   <= 1'b0;
      r_sel   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      w_state <= w_state_d;
      r_state <= r_state_d;
      w_sel   <= w_sel_d;
      r_sel   <= r_sel_d;
      aw_done <= aw_done_d;
      w_done  <= w_done_d;
    end
  end

  // ---------------------------------------------------------------------
  // Write channel datapath: granted port's signals, gated by phase
  // ---------------------------------------------------------------------
  logic w_addr_ph, w_resp_ph, aw_open, w_open;
  logic g_aw_valid, g_w_valid, g_b_ready;

  assign w_addr_ph  = (w_state == W_ADDR);
  assign w_resp_ph  = (w_state == W_RESP);
  assign aw_open    = w_addr_ph & ~aw_done;
  assign w_open     = w_addr_ph & ~w_done;
  assign g_aw_valid = w_sel ? s1_aw_valid : s0_aw_valid;
  assign g_w_valid  = w_sel ? s1_w_valid  : s0_w_valid;
  assign g_b_ready  = w_sel ? s1_b_ready  : s0_b_ready;

  assign m_aw_valid = aw_open & g_aw_valid;
  assign m_aw_addr  = aw_open ? (w_sel ? s1_aw_addr : s0_aw_addr) : '0;
  assign m_aw_prot  = aw_open ? (w_sel ? s1_aw_prot : s0_aw_prot) : '0;
  assign m_w_valid  = w_open & g_w_valid;
  assign m_w_data   = w_open ? (w_sel ? s1_w_data : s0_w_data) : '0;
  assign m_w_strb   = w_open ? (w_sel ? s1_w_strb : s0_w_strb) : '0;
  assign m_b_ready  = w_resp_ph & g_b_ready;

  assign s0_aw_ready = aw_open & ~w_sel & m_aw_ready;
  assign s1_aw_ready = aw_open &  w_sel & m_aw_ready;
  assign s0_w_ready  = w_open  & ~w_sel & m_w_ready;
  assign s1_w_ready  = w_open  &  w_sel & m_w_ready;
  assign s0_b_valid  = w_resp_ph & ~w_sel & m_b_valid;
  assign s1_b_valid  = w_resp_ph &  w_sel & m_b_valid;
  assign s0_b_resp   = (w_resp_ph & ~w_sel) ? m_b_resp : 2'b00;
  assign s1_b_resp   = (w_resp_ph &  w_sel) ? m_b_resp : 2'b00;

  assign wr_gnt       = (w_state == W_IDLE) ? 2'b00 : (w_sel ? 2'b10 : 2'b01);
  assign wr_state_dbg = w_state;

  // Write FSM next state
  always_comb begin
    w_state_d = w_state;
    w_sel_d   = w_sel;
    aw_done_d = aw_done;
    w_done_d  = w_done;
    w_flip    = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        if (s0_aw_valid | s1_aw_valid) begin
          w_sel_d   = w_pick;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = W_ADDR;
        end
      end
      W_ADDR: begin
        // AW and W may be accepted in either order or together.
        aw_done_d = aw_done | (m_aw_valid & m_aw_ready);
        w_done_d  = w_done  | (m_w_valid  & m_w_ready);
        if (aw_done_d & w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (m_b_valid & m_b_ready) begin
          w_flip    = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Read channel datapath
  // ---------------------------------------------------------------------
  logic r_addr_ph, r_data_ph, g_ar_valid, g_r_ready;

  assign r_addr_ph  = (r_state == R_ADDR);
  assign r_data_ph  = (r_state == R_DATA);
  assign g_ar_valid = r_sel ? s1_ar_valid : s0_ar_valid;
  assign g_r_ready  = r_sel ? s1_r_ready  : s0_r_ready;

  assign m_ar_valid = r_addr_ph & g_ar_valid;
  assign m_ar_addr  = r_addr_ph ? (r_sel ? s1_ar_addr : s0_ar_addr) : '0;
  assign m_ar_prot  = r_addr_ph ? (r_sel ? s1_ar_prot : s0_ar_prot) : '0;
  assign m_r_ready  = r_data_ph & g_r_ready;

  assign s0_ar_ready = r_addr_ph & ~r_sel & m_ar_ready;
  assign s1_ar_ready = r_addr_ph &  r_sel & m_ar_ready;
  assign s0_r_valid  = r_data_ph & ~r_sel & m_r_valid;
  assign s1_r_valid  = r_data_ph &  r_sel & m_r_valid;
  assign s0_r_data   = (r_data_ph & ~r_sel) ? m_r_data : '0;
  assign s1_r_data   = (r_data_ph &  r_sel) ? m_r_data : '0;
  assign s0_r_resp   = (r_data_ph & ~r_sel) ? m_r_resp : 2'b00;
  assign s1_r_resp   = (r_data_ph &  r_sel) ? m_r_resp : 2'b00;

  assign rd_gnt       = (r_state == R_IDLE) ? 2'b00 : (r_sel ? 2'b10 : 2'b01);
  assign rd_state_dbg = r_state;

  // Read FSM next state
  always_comb begin
    r_state_d = r_state;
    r_sel_d   = r_sel;
    r_flip    = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        if (s0_ar_valid | s1_ar_valid) begin
          r_sel_d   = r_pick;
          r_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        if (m_ar_valid & m_ar_ready) r_state_d = R_DATA;
      end
      R_DATA: begin
        if (m_r_valid & m_r_ready) begin
          r_flip    = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axil_arb_2to1.sv
// Directed testbench for axil_arb_2to1. A small behavioural AXI4-Lite RAM
// sits on the m_* port. The bench drives requesters s0 and s1 from tasks.
module tb_axil_arb_2to1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  initial forever #5 clk = ~clk;

  // requester-side stimulus (index = port)
  logic [1:0]       s_aw_valid, s_w_valid, s_b_ready, s_ar_valid, s_r_ready;
  logic [1:0][31:0] s_aw_addr, s_w_data, s_ar_addr;
  logic [1:0][2:0]  s_aw_prot, s_ar_prot;
  logic [1:0][3:0]  s_w_strb;
  // requester-side responses
  logic s0_aw_ready, s1_aw_ready, s0_w_ready, s1_w_ready, s0_b_valid, s1_b_valid;
  logic s0_ar_ready, s1_ar_ready, s0_r_valid, s1_r_valid;
  logic [1:0] s0_b_resp, s1_b_resp, s0_r_resp, s1_r_resp;
  logic [31:0] s0_r_data, s1_r_data;
  logic [1:0]       s_aw_ready, s_w_ready, s_b_valid, s_ar_ready, s_r_valid;
  logic [1:0][1:0]  s_b_resp, s_r_resp;
  logic [1:0][31:0] s_r_data;
  assign s_aw_ready = {s1_aw_ready, s0_aw_ready};
  assign s_w_ready  = {s1_w_ready, s0_w_ready};
  assign s_b_valid  = {s1_b_valid, s0_b_valid};
  assign s_ar_ready = {s1_ar_ready, s0_ar_ready};
  assign s_r_valid  = {s1_r_valid, s0_r_valid};
  assign s_b_resp   = {s1_b_resp, s0_b_resp};
  assign s_r_resp   = {s1_r_resp, s0_r_resp};
  assign s_r_data   = {s1_r_data, s0_r_data};

  // downstream
  logic m_aw_valid, m_w_valid, m_b_ready, m_ar_valid, m_r_ready;
  logic [31:0] m_aw_addr, m_w_data, m_ar_addr;
  logic [2:0]  m_aw_prot, m_ar_prot;
  logic [3:0]  m_w_strb;
  logic m_aw_ready, m_w_ready, m_ar_ready;
  logic m_b_valid, m_r_valid;
  logic [1:0] m_b_resp, m_r_resp;
  logic [31:0] m_r_data;
  logic [1:0] wr_gnt, rd_gnt, wr_state_dbg, rd_state_dbg;

  axil_arb_2to1 #(.RR_INIT(1'b0), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_aw_valid(s_aw_valid[0]), .s0_aw_ready(s0_aw_ready), .s0_aw_addr(s_aw_addr[0]),
    .s0_aw_prot(s_aw_prot[0]), .s0_w_valid(s_w_valid[0]), .s0_w_ready(s0_w_ready),
    .s0_w_data(s_w_data[0]), .s0_w_strb(s_w_strb[0]), .s0_b_valid(s0_b_valid),
    .s0_b_ready(s_b_ready[0]), .s0_b_resp(s0_b_resp), .s0_ar_valid(s_ar_valid[0]),
    .s0_ar_ready(s0_ar_ready), .s0_ar_addr(s_ar_addr[0]), .s0_ar_prot(s_ar_prot[0]),
    .s0_r_valid(s0_r_valid), .s0_r_ready(s_r_ready[0]), .s0_r_data(s0_r_data),
    .s0_r_resp(s0_r_resp),
    .s1_aw_valid(s_aw_valid[1]), .s1_aw_ready(s1_aw_ready), .s1_aw_addr(s_aw_addr[1]),
    .s1_aw_prot(s_aw_prot[1]), .s1_w_valid(s_w_valid[1]), .s1_w_ready(s1_w_ready),
    .s1_w_data(s_w_data[1]), .s1_w_strb(s_w_strb[1]), .s1_b_valid(s1_b_valid),
    .s1_b_ready(s_b_ready[1]), .s1_b_resp(s1_b_resp), .s1_ar_valid(s_ar_valid[1]),
    .s1_ar_ready(s1_ar_ready), .s1_ar_addr(s_ar_addr[1]), .s1_ar_prot(s_ar_prot[1]),
    .s1_r_valid(s1_r_valid), .s1_r_ready(s_r_ready[1]), .s1_r_data(s1_r_data),
    .s1_r_resp(s1_r_resp),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr),
    .m_aw_prot(m_aw_prot), .m_w_valid(m_w_valid), .m_w_ready(m_w_ready),
    .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_b_valid(m_b_valid),
    .m_b_ready(m_b_ready), .m_b_resp(m_b_resp), .m_ar_valid(m_ar_valid),
    .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr), .m_ar_prot(m_ar_prot),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data),
    .m_r_resp(m_r_resp),
    .wr_gnt(wr_gnt), .rd_gnt(rd_gnt), .wr_state_dbg(wr_state_dbg), .rd_state_dbg(rd_state_dbg)
  );

  // ---------------- behavioural RAM on the m port ----------------
  logic [31:0] mem [0:63];
  logic        have_aw, have_w;
  logic [31:0] aw_q, wd_q;
  logic [3:0]  ws_q;
  logic [1:0]  slv_bresp = 2'b00;
  logic [1:0]  slv_rresp = 2'b00;

  assign m_aw_ready = 1'b1;
  assign m_w_ready  = 1'b1;
  assign m_ar_ready = 1'b1;

  initial for (int i = 0; i < 64; i++) mem[i] = 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_aw <= 1'b0; have_w <= 1'b0; aw_q <= '0; wd_q <= '0; ws_q <= '0;
      m_b_valid <= 1'b0; m_b_resp <= 2'b00;
      m_r_valid <= 1'b0; m_r_data <= '0; m_r_resp <= 2'b00;
    end else begin
      if (m_aw_valid && m_aw_ready) begin have_aw <= 1'b1; aw_q <= m_aw_addr; end
      if (m_w_valid && m_w_ready) begin have_w <= 1'b1; wd_q <= m_w_data; ws_q <= m_w_strb; end
      if (have_aw && have_w && !m_b_valid) begin
        for (int i = 0; i < 4; i++)
          if (ws_q[i]) mem[aw_q[7:2]][8*i +: 8] <= wd_q[8*i +: 8];
        have_aw <= 1'b0; have_w <= 1'b0;
        m_b_valid <= 1'b1; m_b_resp <= slv_bresp;
      end else if (m_b_valid && m_b_ready) begin
        m_b_valid <= 1'b0;
      end
      if (m_ar_valid && m_ar_ready) begin
        m_r_valid <= 1'b1; m_r_data <= mem[m_ar_addr[7:2]]; m_r_resp <= slv_rresp;
      end else if (m_r_valid && m_r_ready) begin
        m_r_valid <= 1'b0;
      end
    end
  end

  // ---------------- monitors (sampled 1 time unit before posedge) ----------------
  int m_aw_hs = 0, m_w_hs = 0, m_ar_hs = 0;
  int b_beats [2] = '{0, 0};
  int r_beats [2] = '{0, 0};
  logic [1:0] wr_log[$];
  logic [1:0] rd_log[$];
  int wr_gap[$];
  int wr_idle = 0;
  logic [1:0] wr_prev = 2'b00, rd_prev = 2'b00;

  always @(negedge clk) begin
    #4;
    if (rst_n) begin
      if (m_aw_valid && m_aw_ready) m_aw_hs++;
      if (m_w_valid && m_w_ready) m_w_hs++;
      if (m_ar_valid && m_ar_ready) m_ar_hs++;
      for (int p = 0; p < 2; p++) begin
        if (s_b_valid[p] && s_b_ready[p]) b_beats[p]++;
        if (s_r_valid[p] && s_r_ready[p]) r_beats[p]++;
      end
    end
    if (wr_gnt == 2'b00) wr_idle++;
    else if (wr_prev == 2'b00) begin
      wr_log.push_back(wr_gnt); wr_gap.push_back(wr_idle); wr_idle = 0;
    end
    if (rd_gnt != 2'b00 && rd_prev == 2'b00) rd_log.push_back(rd_gnt);
    wr_prev = wr_gnt;
    rd_prev = rd_gnt;
  end

  // ---------------- driver tasks (called at a negedge, return at a negedge) ----------------
  task automatic do_write(input int p, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int w_lead, output logic [1:0] resp);
    int n;
    logic aw_hs, w_hs, done;
    resp = 2'bxx;
    s_w_data[p] = data; s_w_strb[p] = strb; s_w_valid[p] = 1'b1;
    for (int i = 0; i < w_lead; i++) begin
      #1;
      checks++;
      if (s_w_ready[p] !== 1'b0) begin
        errors++;
        $display("FAIL w_ready_before_aw port %0d got %b want 0", p, s_w_ready[p]);
      end
      @(negedge clk);
    end
    s_aw_addr[p] = addr; s_aw_prot[p] = 3'b000; s_aw_valid[p] = 1'b1;
    n = 0;
    while (s_aw_valid[p] || s_w_valid[p]) begin
      #1;
      aw_hs = s_aw_valid[p] & s_aw_ready[p];
      w_hs  = s_w_valid[p] & s_w_ready[p];
      @(negedge clk);
      if (aw_hs) begin s_aw_valid[p] = 1'b0; s_aw_addr[p] = '0; end
      if (w_hs) begin s_w_valid[p] = 1'b0; s_w_data[p] = '0; end
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL write_addr_timeout port %0d got no handshake want handshake", p);
        s_aw_valid[p] = 1'b0; s_w_valid[p] = 1'b0;
      end
    end
    s_b_ready[p] = 1'b1;
    n = 0; done = 1'b0;
    while (!done) begin
      #1;
      if (s_b_valid[p]) begin resp = s_b_resp[p]; done = 1'b1; end
      else if (n > 200) begin
        checks++; errors++;
        $display("FAIL write_resp_timeout port %0d got no b_valid want b_valid", p);
        done = 1'b1;
      end
      n++;
      @(negedge clk);
    end
    s_b_ready[p] = 1'b0;
  endtask

  task automatic do_read(input int p, input logic [31:0] addr,
                         output logic [31:0] data, output logic [1:0] resp);
    int n;
    logic done;
    data = 'x; resp = 2'bxx;
    s_ar_addr[p] = addr; s_ar_prot[p] = 3'b000; s_ar_valid[p] = 1'b1;
    n = 0; done = 1'b0;
    while (!done) begin
      #1;
      if (s_ar_ready[p]) done = 1'b1;
      else if (n > 200) begin
        checks++; errors++;
        $display("FAIL read_addr_timeout port %0d got no ar_ready want ar_ready", p);
        done = 1'b1;
      end
      n++;
      @(negedge clk);
    end
    s_ar_valid[p] = 1'b0; s_ar_addr[p] = '0;
    s_r_ready[p] = 1'b1;
    n = 0; done = 1'b0;
    while (!done) begin
      #1;
      if (s_r_valid[p]) begin data = s_r_data[p]; resp = s_r_resp[p]; done = 1'b1; end
      else if (n > 200) begin
        checks++; errors++;
        $display("FAIL read_data_timeout port %0d got no r_valid want r_valid", p);
        done = 1'b1;
      end
      n++;
      @(negedge clk);
    end
    s_r_ready[p] = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk); @(negedge clk); #1;
    checks++; if (wr_gnt !== 2'b00) begin errors++; $display("FAIL reset_wr_gnt got %b want 00", wr_gnt); end
    checks++; if (rd_gnt !== 2'b00) begin errors++; $display("FAIL reset_rd_gnt got %b want 00", rd_gnt); end
    checks++; if ({m_aw_valid, m_w_valid, m_ar_valid, m_b_ready, m_r_ready} !== 5'b0) begin
      errors++; $display("FAIL reset_m_ctrl got %b want 00000", {m_aw_valid, m_w_valid, m_ar_valid, m_b_ready, m_r_ready}); end
    checks++; if ({m_aw_addr, m_w_data, m_w_strb, m_ar_addr} !== '0) begin
      errors++; $display("FAIL reset_m_data got %h/%h/%h/%h want 0", m_aw_addr, m_w_data, m_w_strb, m_ar_addr); end
    checks++; if ({s_aw_ready, s_w_ready, s_ar_ready, s_b_valid, s_r_valid} !== 10'b0) begin
      errors++; $display("FAIL reset_s_ctrl got %b want 0", {s_aw_ready, s_w_ready, s_ar_ready, s_b_valid, s_r_valid}); end
    checks++; if ({wr_state_dbg, rd_state_dbg} !== 4'b0) begin
      errors++; $display("FAIL reset_state got %b want 0000", {wr_state_dbg, rd_state_dbg}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    logic [1:0] resp, rresp;
    logic [31:0] rdata;
    int aw0, w0, b0, b1;
    aw0 = m_aw_hs; w0 = m_w_hs; b0 = b_beats[0]; b1 = b_beats[1];
    fork
      do_write(0, 32'h10, 32'hDEADBEEF, 4'hF, 0, resp);
      begin
        @(negedge clk); #2;
        checks++; if (wr_gnt !== 2'b01) begin errors++; $display("FAIL single_wr_gnt got %b want 01", wr_gnt); end
        checks++; if (m_aw_valid !== 1'b1 || m_aw_addr !== 32'h10) begin
          errors++; $display("FAIL single_m_aw got valid %b addr %h want 1 00000010", m_aw_valid, m_aw_addr); end
        checks++; if (m_w_data !== 32'hDEADBEEF || m_w_strb !== 4'hF) begin
          errors++; $display("FAIL single_m_w got %h/%h want deadbeef/f", m_w_data, m_w_strb); end
      end
    join
    @(negedge clk);
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL single_b_resp got %b want 00", resp); end
    checks++; if (m_aw_hs - aw0 != 1 || m_w_hs - w0 != 1) begin
      errors++; $display("FAIL single_m_hs got aw %0d w %0d want 1 1", m_aw_hs - aw0, m_w_hs - w0); end
    checks++; if (b_beats[0] - b0 != 1 || b_beats[1] - b1 != 0) begin
      errors++; $display("FAIL single_b_beats got s0 %0d s1 %0d want 1 0", b_beats[0] - b0, b_beats[1] - b1); end
    fork
      do_read(0, 32'h10, rdata, rresp);
      begin
        @(negedge clk); #2;
        checks++; if (rd_gnt !== 2'b01) begin errors++; $display("FAIL single_rd_gnt got %b want 01", rd_gnt); end
      end
    join
    checks++; if (rdata !== 32'hDEADBEEF || rresp !== 2'b00) begin
      errors++; $display("FAIL single_readback got %h/%b want deadbeef/00", rdata, rresp); end
  endtask

  task automatic test_contest_write();
    logic [1:0] r0, r1;
    pulse_reset();
    wr_log.delete(); wr_gap.delete();
    fork
      do_write(0, 32'h30, 32'hA5A50001, 4'hF, 0, r0);
      do_write(1, 32'h34, 32'h5A5A0002, 4'hF, 0, r1);
    join
    @(negedge clk);
    checks++; if (wr_log.size() != 2 || wr_log[0] !== 2'b01 || wr_log[1] !== 2'b10) begin
      errors++; $display("FAIL contest_order got %p want 01,10", wr_log); end
    checks++; if (wr_gap.size() != 2 || wr_gap[1] != 1) begin
      errors++; $display("FAIL contest_gap got %p want second gap 1", wr_gap); end
    // s0 alone, so the next contest belongs to s1
    do_write(0, 32'h38, 32'h00000003, 4'hF, 0, r0);
    wr_log.delete();
    fork
      do_write(0, 32'h30, 32'h11110004, 4'hF, 0, r0);
      do_write(1, 32'h34, 32'h22220005, 4'hF, 0, r1);
    join
    checks++; if (wr_log.size() != 2 || wr_log[0] !== 2'b10 || wr_log[1] !== 2'b01) begin
      errors++; $display("FAIL contest_rr got %p want 10,01", wr_log); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] r0, r1, r2;
    do_write(1, 32'h3C, 32'h00000006, 4'hF, 0, r1);   // hands priority to s0
    wr_log.delete();
    fork
      begin
        do_write(0, 32'h30, 32'h33330007, 4'hF, 0, r0);
        do_write(0, 32'h30, 32'h44440008, 4'hF, 0, r2);
      end
      do_write(1, 32'h34, 32'h55550009, 4'hF, 0, r1);
    join
    checks++; if (wr_log.size() != 3 || wr_log[0] !== 2'b01 || wr_log[1] !== 2'b10 || wr_log[2] !== 2'b01) begin
      errors++; $display("FAIL b2b_order got %p want 01,10,01", wr_log); end
    checks++; if (mem[12] !== 32'h44440008 || mem[13] !== 32'h55550009) begin
      errors++; $display("FAIL b2b_mem got %h/%h want 44440008/55550009", mem[12], mem[13]); end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] resp;
    int aw0, w0;
    aw0 = m_aw_hs; w0 = m_w_hs;
    do_write(1, 32'h40, 32'hCAFEF00D, 4'h3, 2, resp);
    @(negedge clk);
    checks++; if (m_aw_hs - aw0 != 1 || m_w_hs - w0 != 1) begin
      errors++; $display("FAIL wlead_hs got aw %0d w %0d want 1 1", m_aw_hs - aw0, m_w_hs - w0); end
    checks++; if (resp !== 2'b00 || mem[16] !== 32'h0000F00D) begin
      errors++; $display("FAIL wlead_result got %b/%h want 00/0000f00d", resp, mem[16]); end
  endtask

  task automatic test_concurrent();
    logic [1:0] wresp, rresp, tmp;
    logic [31:0] rdata;
    int r0, b1;
    do_write(1, 32'h24, 32'h12345678, 4'hF, 0, tmp);
    r0 = r_beats[0]; b1 = b_beats[1];
    fork
      do_write(0, 32'h20, 32'h0BADF00D, 4'hF, 0, wresp);
      do_read(1, 32'h24, rdata, rresp);
      begin
        @(negedge clk); #2;
        checks++; if (wr_gnt !== 2'b01 || rd_gnt !== 2'b10) begin
          errors++; $display("FAIL conc_gnt got wr %b rd %b want 01 10", wr_gnt, rd_gnt); end
      end
    join
    @(negedge clk);
    checks++; if (wresp !== 2'b00 || rdata !== 32'h12345678 || mem[8] !== 32'h0BADF00D) begin
      errors++; $display("FAIL conc_result got %b/%h/%h want 00/12345678/0badf00d", wresp, rdata, mem[8]); end
    checks++; if (r_beats[0] != r0 || b_beats[1] != b1) begin
      errors++; $display("FAIL conc_stray got s0 r %0d s1 b %0d want 0 0", r_beats[0] - r0, b_beats[1] - b1); end
  endtask

  task automatic test_errors();
    logic [1:0] resp;
    logic [31:0] rdata;
    slv_bresp = 2'b10;
    do_write(1, 32'h28, 32'h00000001, 4'hF, 0, resp);
    checks++; if (resp !== 2'b10) begin errors++; $display("FAIL slverr_fwd got %b want 10", resp); end
    slv_bresp = 2'b00;
    slv_rresp = 2'b11;
    do_read(0, 32'h10, rdata, resp);
    checks++; if (resp !== 2'b11 || rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL decerr_fwd got %b/%h want 11/deadbeef", resp, rdata); end
    slv_rresp = 2'b00;
  endtask

  task automatic test_reset_mid();
    int stray;
    s_aw_addr[0] = 32'h44; s_w_data[0] = 32'h77777777; s_w_strb[0] = 4'hF;
    s_aw_valid[0] = 1'b1; s_w_valid[0] = 1'b1; s_b_ready[0] = 1'b0;
    @(negedge clk);                       // granted, handshakes pending
    @(negedge clk);                       // AW/W accepted, now in W_RESP
    s_aw_valid[0] = 1'b0; s_w_valid[0] = 1'b0;
    @(negedge clk); #1;                   // RAM has raised b_valid
    checks++; if (m_b_valid !== 1'b1 || s0_b_valid !== 1'b1 || wr_state_dbg !== 2'd2) begin
      errors++; $display("FAIL midrst_pre got m_b %b s0_b %b st %0d want 1 1 2", m_b_valid, s0_b_valid, wr_state_dbg); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (wr_gnt !== 2'b00 || s_b_valid !== 2'b00 || m_b_ready !== 1'b0 || wr_state_dbg !== 2'd0) begin
      errors++; $display("FAIL midrst_now got gnt %b b %b m_b_ready %b st %0d want 00 00 0 0",
                         wr_gnt, s_b_valid, m_b_ready, wr_state_dbg); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    s_b_ready[0] = 1'b1;
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      #1; if (s_b_valid !== 2'b00 || wr_gnt !== 2'b00) stray++;
      @(negedge clk);
    end
    s_b_ready[0] = 1'b0;
    checks++; if (stray != 0) begin errors++; $display("FAIL midrst_replay got %0d cycles with b/gnt want 0", stray); end
  endtask

  task automatic test_read_contest();
    logic [31:0] d0 [3];
    logic [31:0] d1 [3];
    logic [1:0] rr0, rr1;
    logic [1:0] exp_q[$];
    int bad;
    rd_log.delete();
    fork
      for (int i = 0; i < 3; i++) do_read(0, 32'h10, d0[i], rr0);
      for (int j = 0; j < 3; j++) do_read(1, 32'h24, d1[j], rr1);
    join
`ifdef AXIL_ARB_FIXED_PRIO_EN
    exp_q = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10};
`else
    exp_q = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`endif
    checks++; if (rd_log.size() != 6) begin
      errors++; $display("FAIL rd_contest_count got %0d want 6", rd_log.size()); end
    else begin
      bad = 0;
      for (int k = 0; k < 6; k++) if (rd_log[k] !== exp_q[k]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL rd_contest_order got %p want %p", rd_log, exp_q); end
    end
    bad = 0;
    for (int k = 0; k < 3; k++) if (d0[k] !== 32'hDEADBEEF || d1[k] !== 32'h12345678) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rd_contest_data got %0d wrong beats want 0", bad); end
  endtask

  initial begin
    s_aw_valid = '0; s_w_valid = '0; s_b_ready = '0; s_ar_valid = '0; s_r_ready = '0;
    s_aw_addr = '0; s_w_data = '0; s_ar_addr = '0; s_aw_prot = '0; s_ar_prot = '0; s_w_strb = '0;
    test_reset();
    test_single_write();
    test_contest_write();
    test_back_to_back();
    test_w_before_aw();
    test_concurrent();
    test_errors();
    test_reset_mid();
    test_read_contest();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
